// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder on a word array.
// Fixed wait states, byte/half/word access, one-cycle response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_write,
  output logic [31:0] mem_read,
  output logic        resp_valid,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  wcnt;
  logic [3:0]  wcnt_nx;
  logic        run;
  logic        accept;
  logic        commit;

  logic        l_wr;
  logic        l_rd;
  logic [31:0] l_addr;
  logic [2:0]  l_f3;
  logic [31:0] l_wdata;

  logic        c_wr;
  logic        c_rd;
  logic [31:0] c_addr;
  logic [2:0]  c_f3;
  logic [31:0] c_wdata;

  logic [29:0] idx;
  logic [1:0]  off;
  logic [AW-1:0] widx;
  logic        oor;
  logic        bad;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic [31:0] word;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ldata;
  logic [31:0] sdata;
  logic [3:0]  be;

  logic [31:0] mem [DEPTH_WORDS];

  // run holds ready low until the first edge after reset release
  assign req_ready  = run && (state == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_RESP);
  assign commit     = (state_nx == S_RESP) && (state != S_RESP);

  // state, wait counter and run flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      run   <= 1'b1;
    end
  end

  // next-state and wait counter
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            wcnt_nx  = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (wcnt == 4'd0) begin
          state_nx = S_RESP;
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // capture request fields at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_wr    <= 1'b0;
      l_rd    <= 1'b0;
      l_addr  <= '0;
      l_f3    <= '0;
      l_wdata <= '0;
    end else if (accept) begin
      l_wr    <= wr_en;
      l_rd    <= rd_en;
      l_addr  <= addr;
      l_f3    <= funct3;
      l_wdata <= mem_write;
    end
  end

  // zero-wait accepts commit on the accept edge, so use live inputs
  assign c_wr    = (state == S_IDLE) ? wr_en     : l_wr;
  assign c_rd    = (state == S_IDLE) ? rd_en     : l_rd;
  assign c_addr  = (state == S_IDLE) ? addr      : l_addr;
  assign c_f3    = (state == S_IDLE) ? funct3    : l_f3;
  assign c_wdata = (state == S_IDLE) ? mem_write : l_wdata;

  assign idx  = c_addr[31:2];
  assign off  = c_addr[1:0];
  assign widx = idx[AW-1:0];
  assign oor  = idx >= 30'(DEPTH_WORDS);
  assign sz_b = (c_f3[1:0] == 2'b00);
  assign sz_h = (c_f3[1:0] == 2'b01);
  assign sz_w = (c_f3[1:0] == 2'b10);

  assign bad = (c_wr == c_rd)
             | oor
             | (c_f3[1:0] == 2'b11)
             | (c_f3[2] & (c_wr | c_f3[1]))
             | (sz_h & off[0])
             | (sz_w & (off != 2'b00));

  assign word = mem[widx];
  assign bsel = 8'(word >> {off, 3'b000});
  assign hsel = off[1] ? word[31:16] : word[15:0];

  // load extraction and store lane placement
  always_comb begin
    ldata = '0;
    sdata = '0;
    be    = '0;
    unique case (1'b1)
      sz_b: begin
        ldata = {{24{~c_f3[2] & bsel[7]}}, bsel};
        sdata = {4{c_wdata[7:0]}};
        be    = 4'b0001 << off;
      end
      sz_h: begin
        ldata = {{16{~c_f3[2] & hsel[15]}}, hsel};
        sdata = {2{c_wdata[15:0]}};
        be    = off[1] ? 4'b1100 : 4'b0011;
      end
      sz_w: begin
        ldata = word;
        sdata = c_wdata;
        be    = 4'b1111;
      end
      default: begin
        ldata = '0;
      end
    endcase
  end

  // array write on the edge entering RESP
  always_ff @(posedge clk) begin
    if (commit && c_wr && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= sdata[8*i +: 8];
        end
      end
    end
  end

  // response data held only through the RESP cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read <= '0;
      err      <= 1'b0;
    end else if (commit) begin
      err      <= bad;
      mem_read <= (bad || c_wr) ? 32'd0 : ldata;
    end else begin
      mem_read <= '0;
      err      <= 1'b0;
    end
  end

endmodule
